// File: rtl/sa_result_collector.sv
// Deskews the 4x4 systolic array's bottom partial-sum stream into a 4x4 result buffer
// and serves it as 32-bit words. Optional macro SA_RESULT_ACCUM_EN accumulates across captures.
module sa_result_collector #(
    parameter int FIRST_STEP = 4,
    parameter int DATA_W     = 16
) (
    input  logic                Clock,
    input  logic                rst,
    input  logic                data_clear,
    input  logic                start,
    input  logic                shift_en,
    input  logic [4*DATA_W-1:0] ps_bottom_out_flat,
    input  logic                rd_en,
    input  logic [2:0]          rd_addr,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(FIRST_STEP + 6);

    state_t            state;
    logic [3:0]        step;
    logic [DATA_W-1:0] res [4][4];
    logic [DATA_W-1:0] col_sample [4];
    logic [15:0]       wr_hit;

    assign state_dbg = state;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            col_sample[j] = ps_bottom_out_flat[DATA_W*j +: DATA_W];
        end
    end

    // Anti-diagonal decode: cell (i,j) is at the array bottom when step == FIRST_STEP+i+j.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                wr_hit[4*i+j] = (state == ST_CAPTURE) && shift_en &&
                                (step == 4'(FIRST_STEP + i + j));
            end
        end
    end

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    res[i][j] <= '0;
                end
            end
        end else if (data_clear) begin
            state   <= ST_IDLE;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    res[i][j] <= '0;
                end
            end
        end else if (start) begin
            state   <= ST_CAPTURE;
            step    <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            overrun <= 1'b0;
`ifndef SA_RESULT_ACCUM_EN
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    res[i][j] <= '0;
                end
            end
`endif
        end else if (shift_en) begin
            case (state)
                ST_CAPTURE: begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            if (wr_hit[4*i+j]) begin
`ifdef SA_RESULT_ACCUM_EN
                                res[i][j] <= res[i][j] + col_sample[j];
`else
                                res[i][j] <= col_sample[j];
`endif
                            end
                        end
                    end
                    step <= step + 4'd1;
                    if (step == LAST_STEP) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    overrun <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Read port samples the buffer before this edge's capture write lands.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_addr[0]) begin
                    rd_data <= {res[rd_addr[2:1]][3], res[rd_addr[2:1]][2]};
                end else begin
                    rd_data <= {res[rd_addr[2:1]][1], res[rd_addr[2:1]][0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed bench for sa_result_collector: capture, gating, overrun, restart, clear, read timing.
module tb_sa_result_collector;

    localparam int FS = 4;

    logic        clk;
    logic        rst;
    logic        data_clear;
    logic        start;
    logic        shift_en;
    logic [63:0] ps_bottom_out_flat;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    sa_result_collector #(.FIRST_STEP(FS), .DATA_W(16)) dut (
        .Clock(clk),
        .rst(rst),
        .data_clear(data_clear),
        .start(start),
        .shift_en(shift_en),
        .ps_bottom_out_flat(ps_bottom_out_flat),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .busy(busy),
        .done(done),
        .overrun(overrun),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column j carries R[i][j] = 16*i+j at step FS+i+j; other steps carry junk.
    function automatic logic [63:0] bus_for_step(input int s);
        logic [63:0] b;
        int i;
        b = '0;
        for (int j = 0; j < 4; j++) begin
            i = s - FS - j;
            if (i >= 0 && i < 4) b[16*j +: 16] = 16'(16*i + j);
            else                 b[16*j +: 16] = 16'hDEAD;
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        int row;
        int half;
        row  = a / 2;
        half = a % 2;
        return {16'(16*row + 2*half + 1), 16'(16*row + 2*half)};
    endfunction

    task automatic run_steps(input int first_s, input int n, input bit gapped);
        for (int s = first_s; s < first_s + n; s++) begin
            if (gapped) begin
                shift_en = 1'b0;
                ps_bottom_out_flat = 64'hFFFF_FFFF_FFFF_FFFF;
                tick();
            end
            shift_en = 1'b1;
            ps_bottom_out_flat = bus_for_step(s);
            tick();
            shift_en = 1'b0;
        end
    endtask

    task automatic run_const(input logic [15:0] v);
        for (int s = 0; s < FS + 7; s++) begin
            shift_en = 1'b1;
            ps_bottom_out_flat = {v, v, v, v};
            tick();
        end
        shift_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        data_clear = 1'b1;
        tick();
        data_clear = 1'b0;
    endtask

    task automatic clean_start();
`ifdef SA_RESULT_ACCUM_EN
        pulse_clear();
`endif
        pulse_start();
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        rd_en = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, rd_data, exp);
    endtask

    task automatic read_all_model(input string tag);
        for (int a = 0; a < 8; a++) read_check($sformatf("%s_a%0d", tag, a), 3'(a), exp_word(a));
    endtask

    task automatic read_all_const(input string tag, input logic [31:0] v);
        for (int a = 0; a < 8; a++) read_check($sformatf("%s_a%0d", tag, a), 3'(a), v);
    endtask

    initial begin
        rst = 1'b1;
        data_clear = 1'b0;
        start = 1'b0;
        shift_en = 1'b0;
        ps_bottom_out_flat = '0;
        rd_en = 1'b0;
        rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        read_all_const("rst_read", 32'd0);
        tick();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Ungapped capture with a same-cycle read of a cell being written
        clean_start();
        check("cap_busy", {31'd0, busy}, 32'd1);
        check("cap_state", {30'd0, state_dbg}, 32'd1);
        run_steps(0, 4, 1'b0);
        rd_en = 1'b1;
        rd_addr = 3'd0;
        run_steps(4, 1, 1'b0);
        rd_en = 1'b0;
        check("rbw_old_data", rd_data, 32'd0);
        run_steps(5, 5, 1'b0);
        check("cap_done_early", {31'd0, done}, 32'd0);
        check("cap_busy_early", {31'd0, busy}, 32'd1);
        run_steps(10, 1, 1'b0);
        check("cap_done", {31'd0, done}, 32'd1);
        check("cap_busy_end", {31'd0, busy}, 32'd0);
        check("cap_state_done", {30'd0, state_dbg}, 32'd2);
        read_check("cap_addr5", 3'd5, 32'h0023_0022);
        tick();
        check("rd_hold", rd_data, 32'h0023_0022);
        read_check("cap_addr0", 3'd0, 32'h0001_0000);
        read_all_model("cap");

        // Gated capture gives the same buffer
        clean_start();
        run_steps(0, 10, 1'b1);
        check("gap_done_early", {31'd0, done}, 32'd0);
        run_steps(10, 1, 1'b1);
        check("gap_done", {31'd0, done}, 32'd1);
        read_all_model("gap");

        // Overrun then restart
        shift_en = 1'b1;
        ps_bottom_out_flat = 64'h1234_5678_9ABC_DEF0;
        tick();
        shift_en = 1'b0;
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_state", {30'd0, state_dbg}, 32'd2);
        read_check("ovr_addr5", 3'd5, 32'h0023_0022);
        read_check("ovr_addr6", 3'd6, 32'h0031_0030);
        pulse_start();
        check("restart_ovr", {31'd0, overrun}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
`ifdef SA_RESULT_ACCUM_EN
        read_all_model("restart_keep");
`else
        read_all_const("restart_zero", 32'd0);
`endif

        // Mid-capture restart; the strobe coinciding with start is not counted
        clean_start();
`ifdef SA_RESULT_ACCUM_EN
        for (int s = 0; s < 6; s++) begin
            shift_en = 1'b1;
            ps_bottom_out_flat = '0;
            tick();
        end
        shift_en = 1'b0;
`else
        run_steps(0, 6, 1'b0);
`endif
        start = 1'b1;
        shift_en = 1'b1;
        ps_bottom_out_flat = 64'hBEEF_BEEF_BEEF_BEEF;
        tick();
        start = 1'b0;
        shift_en = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        run_steps(0, 10, 1'b0);
        check("mid_done_early", {31'd0, done}, 32'd0);
        run_steps(10, 1, 1'b0);
        check("mid_done", {31'd0, done}, 32'd1);
        read_all_model("mid");

        // data_clear mid-capture, then shift_en in IDLE is ignored
        clean_start();
        run_steps(0, 6, 1'b0);
        pulse_clear();
        check("clr_state", {30'd0, state_dbg}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        read_all_const("clr", 32'd0);
        run_steps(4, 3, 1'b0);
        check("idle_ovr", {31'd0, overrun}, 32'd0);
        check("idle_state", {30'd0, state_dbg}, 32'd0);
        read_check("idle_addr0", 3'd0, 32'd0);

`ifdef SA_RESULT_ACCUM_EN
        // Two accumulating captures: 3 + 0xFFFF wraps to 2
        pulse_clear();
        pulse_start();
        run_const(16'h0003);
        check("acc1_done", {31'd0, done}, 32'd1);
        read_check("acc1_addr3", 3'd3, 32'h0003_0003);
        pulse_start();
        run_const(16'hFFFF);
        read_all_const("acc2", 32'h0002_0002);
        pulse_clear();
        read_all_const("acc_clr", 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
